mac_sequencer: RTL

//  Job-level controller in front of one mac instance. Takes a start command with nonzero and row counts.

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_sequencer_seq_counter.sv | 31 +++
 rtl/mac_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the mac job sequencer.
//   DOUBLE_W : width of an IEEE double operand
//   state_t  : 3-bit sequencer state, with one localparam constant per state
package mac_pkg;

    localparam int DOUBLE_W = 64;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_STREAM = 3'd1;
    localparam state_t S_DRAIN  = 3'd2;
    localparam state_t S_EOF    = 3'd3;
    localparam state_t S_WAIT   = 3'd4;
    localparam state_t S_DONE   = 3'd5;

endpackage

// File: rtl/mac_sequencer_seq_counter.sv
// Loadable down-counter with enable and terminal count.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (takes priority over en)
//   load_val  : value to load
//   en        : decrement by one; the count stops at zero
//   tc        : high while the count is zero
module seq_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/mac_sequencer.sv
// Job-level controller in front of one mac instance.
// A start command latches the nonzero and row counts. (row, v0, v1) tuples are
// then streamed into mac under mac's stall. After the pipeline has drained, eof
// is pulsed. Result pushes are then counted until every row is out, or until
// the job times out.
//   clk, rst                      : clock, asynchronous active-high reset
//   start, nnz_in, rows_in        : job command (sampled in IDLE only)
//   in_valid/in_ready, in_row/v0/v1 : tuple stream from the fetch path
//   mac_wr, mac_row, mac_v0/v1    : registered tuple write into mac
//   mac_eof                       : one-cycle end-of-input pulse to mac
//   mac_stall, mac_push_out       : mac back-pressure and result strobe
//   mac_stall_out, res_stall      : result back-pressure passed through to mac
//   busy, done, timeout           : job status
//   stall_count, out_count        : per-job statistics
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int ROW_W     = 10,
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 1000,
    parameter int TIMEOUT   = 2**24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    nnz_in,
    input  logic [CNT_W-1:0]    rows_in,
    input  logic                in_valid,
    input  logic [ROW_W-1:0]    in_row,
    input  logic [DOUBLE_W-1:0] in_v0,
    input  logic [DOUBLE_W-1:0] in_v1,
    output logic                in_ready,
    output logic                mac_wr,
    output logic [ROW_W-1:0]    mac_row,
    output logic [DOUBLE_W-1:0] mac_v0,
    output logic [DOUBLE_W-1:0] mac_v1,
    output logic                mac_eof,
    input  logic                mac_stall,
    input  logic                mac_push_out,
    output logic                mac_stall_out,
    input  logic                res_stall,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    out_count
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] nnz_q, rows_q, issued;
    logic             start_acc, accept, last_accept, rows_met;
    logic             drain_load, drain_tc, to_tc;

    assign start_acc   = start && (state == S_IDLE);
    assign in_ready    = (state == S_STREAM) && !mac_stall && (issued < nnz_q);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && ((issued + 1'b1) == nnz_q);
    // >= rather than == so that surplus pushes seen early still end the job
    assign rows_met    = (out_count >= rows_q);

    assign busy          = (state != S_IDLE) && (state != S_DONE);
    assign done          = (state == S_DONE);
    assign mac_eof       = (state == S_EOF);
    assign mac_stall_out = res_stall;

    // An empty job skips STREAM, so the drain count is loaded by start as well
    assign drain_load = (start_acc && nnz_in == '0) || last_accept;

    seq_counter #(.W(CNT_W)) u_drain (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load),
        .load_val (CNT_W'(DRAIN_CYC)),
        .en       ((state == S_DRAIN) && !mac_stall),
        .tc       (drain_tc)
    );

    // The count is loaded in EOF, so WAIT_OUT sees TIMEOUT+1 cycles before it expires
    seq_counter #(.W(CNT_W)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_EOF),
        .load_val (CNT_W'(TIMEOUT)),
        .en       (state == S_WAIT),
        .tc       (to_tc)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = (nnz_in == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: if (last_accept) state_nx = S_DRAIN;
            // A stall holds the drain, including on its final count
            S_DRAIN:  if (drain_tc && !mac_stall) state_nx = S_EOF;
            S_EOF:    state_nx = S_WAIT;
            S_WAIT:   if (rows_met || to_tc) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            nnz_q       <= '0;
            rows_q      <= '0;
            issued      <= '0;
            stall_count <= '0;
            out_count   <= '0;
            timeout     <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_acc) begin
                nnz_q       <= nnz_in;
                rows_q      <= rows_in;
                issued      <= '0;
                stall_count <= '0;
                out_count   <= '0;
                timeout     <= 1'b0;
            end else begin
                if (accept)
                    issued <= issued + 1'b1;
                if (state == S_STREAM && in_valid && mac_stall && stall_count != '1)
                    stall_count <= stall_count + 1'b1;
                if (busy && mac_push_out)
                    out_count <= out_count + 1'b1;
                if (state == S_WAIT && !rows_met && to_tc)
                    timeout <= 1'b1;
            end
        end
    end

    // Tuple register into mac: one-cycle latency, and the data holds between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_wr  <= 1'b0;
            mac_row <= '0;
            mac_v0  <= '0;
            mac_v1  <= '0;
        end else begin
            mac_wr <= accept;
            if (accept) begin
                mac_row <= in_row;
                mac_v0  <= in_v0;
                mac_v1  <= in_v1;
            end
        end
    end

endmodule
